// File: rtl/dcache_wt_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Sits between the core's load/store stage and a word-addressed data memory.
// Read misses refill a whole line word by word. Every store goes to memory,
// and the cached copy is updated only when the stored word is already resident.
//
// Core handshake: a request (cpu_re or cpu_we; cpu_we wins) is accepted on the
// first rising edge where stall=0. While stall=1 the core holds cpu_re, cpu_we,
// cpu_addr and cpu_wd unchanged. A load completes with cpu_rd valid in the
// cycle where stall drops. A store completes in its mem_we cycle.
module dcache_wt_ctrl #(
  parameter int DATA    = 32,
  parameter int ADDR    = 32,
  parameter int LINES   = 16,
  parameter int WORDS   = 4,
  parameter int MEM_LAT = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cpu_re,
  input  logic            cpu_we,
  input  logic [ADDR-1:0] cpu_addr,
  input  logic [DATA-1:0] cpu_wd,
  output logic [DATA-1:0] cpu_rd,
  output logic            stall,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_wd,
  input  logic [DATA-1:0] mem_rd
);

  localparam int OFF_W = $clog2(WORDS);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR - OFF_W - IDX_W;
  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(MEM_LAT - 1);
  localparam logic [OFF_W-1:0] WCNT_LAST = OFF_W'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WRITE  = 2'd1,
    REFILL = 2'd2
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [OFF_W-1:0] wcnt;
  logic [LINES-1:0] valid;
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [DATA-1:0]  data_q [LINES*WORDS];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             hit;
  logic             last_beat;

  assign off       = cpu_addr[OFF_W-1:0];
  assign idx       = cpu_addr[OFF_W +: IDX_W];
  assign tag       = cpu_addr[ADDR-1:OFF_W+IDX_W];
  assign hit       = valid[idx] && (tag_q[idx] == tag);
  assign last_beat = (cnt == CNT_LAST);

  // Outputs decoded from the current state and the held request. All are
  // forced to zero while reset is asserted, so an aborted access stops at once.
  always_comb begin
    stall    = 1'b0;
    mem_we   = 1'b0;
    mem_addr = '0;
    mem_wd   = '0;
    cpu_rd   = '0;
    if (rst_n) begin
      if (hit) cpu_rd = data_q[{idx, off}];
      case (state)
        IDLE:   stall = cpu_we || (cpu_re && !hit);
        WRITE: begin
          mem_addr = cpu_addr;
          mem_wd   = cpu_wd;
          stall    = !last_beat;
          mem_we   = last_beat;
        end
        REFILL: begin
          stall    = 1'b1;
          mem_addr = {cpu_addr[ADDR-1:OFF_W], wcnt};
        end
        default: ;
      endcase
    end
  end

  // Control FSM: access sequencing, latency counters and line valid bits.
  // A line becomes valid only when its last word has arrived.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      wcnt  <= '0;
      valid <= '0;
    end else begin
      case (state)
        IDLE: begin
          cnt  <= '0;
          wcnt <= '0;
          if (cpu_we)               state <= WRITE;
          else if (cpu_re && !hit)  state <= REFILL;
        end
        WRITE: begin
          if (last_beat) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REFILL: begin
          if (last_beat) begin
            cnt <= '0;
            if (wcnt == WCNT_LAST) begin
              wcnt       <= '0;
              valid[idx] <= 1'b1;
              state      <= IDLE;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt   <= '0;
          wcnt  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  // Tag and data arrays: store-hit word update and refill word capture.
  // Conflicting lines are overwritten without writeback since memory is current.
  always_ff @(posedge clk) begin
    if (state == WRITE && last_beat && hit) begin
      data_q[{idx, off}] <= cpu_wd;
    end
    if (state == REFILL && last_beat) begin
      data_q[{idx, wcnt}] <= mem_rd;
      if (wcnt == WCNT_LAST) tag_q[idx] <= tag;
    end
  end

endmodule
